// File: rtl/my_quad_pkg.sv
// my_quad_pkg: state encodings, direction constants and the quadrature transition lookup.
// Rev 1.0
`default_nettype none

package my_quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } quad_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_UP   = 2'd1,
    EV_DN   = 2'd2,
    EV_ERR  = 2'd3
  } quad_event_t;

  typedef struct packed {
    quad_state_t next;
    quad_event_t evt;
  } quad_step_t;

  // The next state is always the new pair; the event says how it was reached.
  function automatic quad_step_t quad_lookup(input quad_state_t cur, input logic [1:0] pair);
    quad_step_t  res;
    quad_state_t up_nxt;
    quad_state_t dn_nxt;
    up_nxt = S10;
    dn_nxt = S01;
    case (cur)
      S00: begin up_nxt = S10; dn_nxt = S01; end
      S10: begin up_nxt = S11; dn_nxt = S00; end
      S11: begin up_nxt = S01; dn_nxt = S10; end
      S01: begin up_nxt = S00; dn_nxt = S11; end
      default: begin up_nxt = S10; dn_nxt = S01; end
    endcase
    res.next = quad_state_t'(pair);
    if (pair == cur)         res.evt = EV_NONE;
    else if (pair == up_nxt) res.evt = EV_UP;
    else if (pair == dn_nxt) res.evt = EV_DN;
    else                     res.evt = EV_ERR;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/my_sync_filter.sv
// my_sync_filter: two-flop synchronizer plus optional stability filter (QUAD_FILTER_EN).
// Rev 1.0
`default_nettype none

module my_sync_filter #(
  parameter int FILT = 4
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic settled
);

  logic [1:0] sync_q;
  logic [1:0] prime_q;
  logic       sync_out;

  // prime_q marks when sync_q[1] holds a real sample rather than its reset value.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b00;
      prime_q <= 2'b00;
    end else begin
      sync_q  <= {sync_q[0], din};
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  assign sync_out = sync_q[1];

`ifdef QUAD_FILTER_EN
  localparam int CW = (FILT < 1) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT - 1);

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_out == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      filt_q <= sync_out;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dout    = filt_q;
  assign settled = prime_q[1] & (sync_out == filt_q);
`else
  assign dout    = sync_out;
  assign settled = prime_q[1];
`endif

  if (FILT < 1) begin : g_filt_check
    $error("my_sync_filter: FILT must be at least 1");
  end

endmodule

`default_nettype wire

// File: rtl/my_quad_decoder.sv
// my_quad_decoder: quadrature front end with x4 decode, error flag and N-bit position.
// Rev 1.0. Define QUAD_FILTER_EN to build the per-phase stability filter.
`default_nettype none

module my_quad_decoder
  import my_quad_pkg::*;
#(
  parameter int N    = 8,
  parameter int FILT = 4
) (
  input  logic         sysclk,
  input  logic         reset_n,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         clr,
  output logic         step,
  output logic         dir,
  output logic         err,
  output logic [N-1:0] pos
);

  logic a_f, b_f, a_ok, b_ok;

  my_sync_filter #(.FILT(FILT)) u_filt_a (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .din    (a_in),
    .dout   (a_f),
    .settled(a_ok)
  );

  my_sync_filter #(.FILT(FILT)) u_filt_b (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .din    (b_in),
    .dout   (b_f),
    .settled(b_ok)
  );

  quad_state_t state_q, state_d;
  quad_step_t  lut;
  logic        init_q, init_d;
  logic        step_d, err_d, dir_d;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S00;
      init_q  <= 1'b1;
      step    <= 1'b0;
      err     <= 1'b0;
      dir     <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      step    <= step_d;
      err     <= err_d;
      dir     <= dir_d;
    end
  end

  // While init is set the first settled pair is adopted silently, so a resting
  // encoder at a non-00 position does not produce a step out of reset.
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir;
    lut     = quad_lookup(state_q, {a_f, b_f});
    if (init_q) begin
      if (a_ok && b_ok) begin
        state_d = quad_state_t'({a_f, b_f});
        init_d  = 1'b0;
      end
    end else begin
      state_d = lut.next;
      case (lut.evt)
        EV_UP:   begin step_d = 1'b1; dir_d = DIR_UP; end
        EV_DN:   begin step_d = 1'b1; dir_d = DIR_DN; end
        EV_ERR:  err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (step) begin
      pos <= (dir == DIR_UP) ? pos + 1'b1 : pos - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/my_quad_decoder.md
# my_quad_decoder

Quadrature encoder front end for board rotary encoders and incremental sensors. Samples the asynchronous A/B phase inputs, synchronizes and glitch-filters them, and decodes the Gray sequence into one-cycle step pulses with direction. It also keeps an N-bit position count. The step/dir outputs connect directly to the en/up inputs of the up/down binary counter.

## Interface
Parameters:
- N, 8, width of the position count.
- FILT, 4, consecutive stable samples needed before a filtered phase level changes (must be at least 1).

Ports:
- sysclk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_in  in  1  phase A, asynchronous to sysclk.
- b_in  in  1  phase B, asynchronous to sysclk.
- clr  in  1  synchronous clear of the position count.
- step  out  1  one-cycle pulse for each valid quadrature edge (x4 decoding).
- dir  out  1  direction of the most recent step; 1 means up (A leads B).
- err  out  1  one-cycle pulse when both filtered phases change in the same cycle.
- pos  out  N  position count, unsigned and modulo 2^N.

## Operation
- Synchronizer: each input passes through a two-flop synchronizer. The flops reset to 0.
- Filter: each phase has a stability counter. The filtered level takes the synchronized value once that value has differed from the filtered level for FILT consecutive cycles. Any mismatch that returns to the filtered level before then resets the counter. Filtered levels reset to 0.
- Decoder: the previous filtered pair {A,B} is held in a 2-bit state register with states S00, S10, S11, S01.
  - Up sequence: S00→S10→S11→S01→S00.
  - Down sequence: the reverse order.
  - Exactly one bit changes in the up direction: step=1, dir=1.
  - Exactly one bit changes in the down direction: step=1, dir=0.
  - Both bits change: err=1, step=0, dir is held, pos is unchanged. The state still moves to the new pair.
  - No change: step=0, err=0.
- Init: after reset, an init flag suppresses decoding. The first cycle after the filters settle loads the state from the filtered pair without producing step or err, then clears the flag. This prevents a spurious step when the encoder rests at a non-00 position.
- Position count:
  - clr=1: pos becomes 0. clr has priority over a step in the same cycle, but step and dir are still output.
  - Otherwise, each step adds 1 or subtracts 1 according to dir.
  - Wrap-around: 2^N−1 +1 → 0, and 0 −1 → 2^N−1, with no flag.
- Reset values: step=0, dir=0, err=0, pos=0, state=S00, init flag set, filter counters=0.
- Reset asserted mid-operation clears everything immediately, including any pending filter progress.

## Timing
- Latency with the filter: a phase edge first captured at sysclk edge k produces step/err high during the cycle following edge k+FILT+2. pos updates at edge k+FILT+3.
- Latency without the filter: step/err high after edge k+2; pos updates at edge k+3.
- step and err are registered. Each is high for exactly one cycle per event, and they are never high together.
- Minimum phase spacing for lossless decoding is FILT+1 cycles between edges. Faster input is treated as a glitch or flagged as err. It is never miscounted silently.

## Configuration
- QUAD_FILTER_EN defined: the stability filter is built as described above.
- QUAD_FILTER_EN undefined: the filter is omitted and the synchronizer outputs feed the decoder directly. FILT is ignored, and latency drops by FILT cycles.
- Decoding, error, and position behaviour are identical in both builds.

## Structure
- Package my_quad_pkg holds:
  - the 2-bit state encodings S00, S10, S11, S01;
  - the DIR_UP and DIR_DN constants;
  - a next-state/direction lookup function used by both the RTL and the scoreboard.
- Sub-module my_sync_filter, instantiated once per phase, contains the two-flop synchronizer and the stability counter. The filter part sits inside the QUAD_FILTER_EN guard.
- The top level holds the decoder state, the init flag, and the position counter.

## Test plan
- Reset with a_in=1, b_in=1 held, then release: no step and no err; pos stays 0 after the filters settle.
- Four full up cycles (16 edges) with 10-cycle edge spacing, FILT=4: 16 step pulses with dir=1, pos=16. Each step appears FILT+3 cycles after its edge.
- At pos=0, apply one down edge: step with dir=0, pos=255 (N=8). Then apply one up edge: pos=0.
- Glitch on a_in of 3 cycles with FILT=4: no step, no err, pos unchanged. Repeat with a 4-cycle glitch: one up step, then one down step.
- Toggle a_in and b_in in the same cycle from S00: one err pulse, no step, pos unchanged. The state becomes S11, and the next edge decodes relative to S11.
- Assert clr in the same cycle a step would increment pos=5: pos=0, step pulse still observed. Assert reset_n low mid-sequence: all outputs return to 0 asynchronously.
